// File: rtl/riscv_pkg.sv
// Shared pipeline types: operand-forwarding select codes and the per-stage
// shadow entry that the hazard controller tracks.
package riscv_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = '0;

endpackage

// File: rtl/fwd_match.sv
// Producer/consumer register match; x0 never matches since it is hardwired.
module fwd_match (
  input  logic [4:0] rs,
  input  logic [4:0] rd,
  input  logic       we,
  input  logic       valid,
  output logic       hit
);

  always_comb begin
    hit = valid && we && (rd == rs) && (rd != 5'd0);
  end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding-select and hazard controller for a 5-stage in-order pipeline:
// tracks EX/MEM/WB destinations, registers EX operand selects, detects load-use.
module forward_hazard_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       ex_branch_taken,
  input  logic       mem_stall,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall,
  output logic       bubble,
  output logic       flush_ifid,
  output logic       flush_idex
);

  shadow_entry_t ex_q, mem_q, wb_q;
  shadow_entry_t id_entry;
  fwd_sel_e      fwd_a_q, fwd_b_q;
  fwd_sel_e      fwd_a_d, fwd_b_d;

  logic a_ex_hit, a_mem_hit, b_ex_hit, b_mem_hit;
  logic a_lu_hit, b_lu_hit;
  logic load_use, flush;

  // id_valid gates every match so a bubble in decode has no sources.
  fwd_match u_a_ex  (.rs(id_rs1), .rd(ex_q.rd),  .we(ex_q.we),    .valid(ex_q.valid  && id_valid), .hit(a_ex_hit));
  fwd_match u_a_mem (.rs(id_rs1), .rd(mem_q.rd), .we(mem_q.we),   .valid(mem_q.valid && id_valid), .hit(a_mem_hit));
  fwd_match u_b_ex  (.rs(id_rs2), .rd(ex_q.rd),  .we(ex_q.we),    .valid(ex_q.valid  && id_valid), .hit(b_ex_hit));
  fwd_match u_b_mem (.rs(id_rs2), .rd(mem_q.rd), .we(mem_q.we),   .valid(mem_q.valid && id_valid), .hit(b_mem_hit));
  fwd_match u_a_lu  (.rs(id_rs1), .rd(ex_q.rd),  .we(ex_q.load),  .valid(ex_q.valid  && id_valid), .hit(a_lu_hit));
  fwd_match u_b_lu  (.rs(id_rs2), .rd(ex_q.rd),  .we(ex_q.load),  .valid(ex_q.valid  && id_valid), .hit(b_lu_hit));

  always_comb begin
    id_entry       = SHADOW_EMPTY;
    id_entry.valid = id_valid;
    id_entry.rd    = id_rd;
    id_entry.we    = id_reg_write;
    id_entry.load  = id_mem_read;

    fwd_a_d = a_ex_hit ? FWD_MEM : (a_mem_hit ? FWD_WB : FWD_REG);
    fwd_b_d = b_ex_hit ? FWD_MEM : (b_mem_hit ? FWD_WB : FWD_REG);

    load_use = a_lu_hit || b_lu_hit;
    flush    = ex_branch_taken && !mem_stall;

    // Memory freeze dominates; a taken branch squashes the stalled consumer.
    stall      = mem_stall || (load_use && !ex_branch_taken);
    bubble     = load_use && !ex_branch_taken && !mem_stall;
    flush_ifid = flush;
    flush_idex = flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= SHADOW_EMPTY;
      mem_q   <= SHADOW_EMPTY;
      wb_q    <= SHADOW_EMPTY;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else if (!mem_stall) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (ex_branch_taken || load_use) begin
        ex_q    <= SHADOW_EMPTY;
        fwd_a_q <= FWD_REG;
        fwd_b_q <= FWD_REG;
      end else begin
        ex_q    <= id_entry;
        fwd_a_q <= fwd_a_d;
        fwd_b_q <= fwd_b_d;
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

endmodule
